muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits in the execute stage of the 5-stage pipeline and replaces the fixed 32-bit divider embedded in the ALU. It implements MULT/MULTU/DIV/DIVU and MTHI/MTLO, and tells the hazard unit to stall the execute stage while an operation is in flight. It also supports cancellation on a pipeline flush.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and sign-fix helper
// for the muldiv_unit execute-stage multiply/divide block.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  typedef struct packed {
    logic neg_lo;
    logic neg_hi;
    logic neg_prod;
  } fix_t;

  // Which parts of a magnitude result need negating.
  // Quotient follows sa^sb, remainder follows the
  // dividend, a product is negated as a whole.
  function automatic fix_t sign_fix(
    input logic [1:0] op,
    input logic       sa,
    input logic       sb
  );
    fix_t f;
    logic sg;
    logic dv;
    sg = (op == OP_MULT) || (op == OP_DIV);
    dv = (op == OP_DIV) || (op == OP_DIVU);
    f.neg_lo   = sg & dv & (sa ^ sb);
    f.neg_hi   = sg & dv & sa;
    f.neg_prod = sg & ~dv & (sa ^ sb);
    return f;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, either a
// restoring-divide step or a shift-add multiply step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_sum;

  assign w_rem_sh = {i_acc, i_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, i_m};
  assign w_sum    = {1'b0, i_acc}
                  + (i_q[0] ? {1'b0, i_m} : '0);

  // Divide: keep the difference when it did not borrow.
  // Multiply: add then shift {acc,q} right by one.
  always_comb begin
    o_acc = i_acc;
    o_q   = i_q;
    if (i_is_div) begin
      if (w_diff[WIDTH]) begin
        o_acc = w_rem_sh[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = w_diff[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      o_acc = w_sum[WIDTH:1];
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  input  logic             i_we_hi,
  input  logic             i_we_lo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  state_e           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_sgn_in;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_q_nx;
  fix_t             w_fix;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_c;
  logic [WIDTH-1:0] w_quo_c;
  logic [WIDTH-1:0] w_rem_c;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_sgn_in = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_neg_a  = w_sgn_in & i_a[WIDTH-1];
  assign w_neg_b  = w_sgn_in & i_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -i_a : i_a;
  assign w_abs_b  = w_neg_b ? -i_b : i_b;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_is_div (r_op[1]),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_m      (r_b),
    .o_acc    (w_acc_nx),
    .o_q      (w_q_nx)
  );

  assign w_fix    = sign_fix(r_op, r_sa, r_sb);
  assign w_prod   = {r_acc, r_q};
  assign w_prod_c = w_fix.neg_prod ? -w_prod : w_prod;
  assign w_quo_c  = w_fix.neg_lo ? -r_q : r_q;
  assign w_rem_c  = w_fix.neg_hi ? -r_acc : r_acc;

  // Divide by zero forces an all-ones quotient; the
  // remainder path already yields the dividend.
  assign w_res_lo = !r_op[1] ? w_prod_c[WIDTH-1:0]
                  : (r_b == '0) ? '1 : w_quo_c;
  assign w_res_hi = !r_op[1] ? w_prod_c[2*WIDTH-1:WIDTH]
                  : w_rem_c;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fprod;
  logic [2*WIDTH-1:0] w_fprod_c;
  assign w_fprod   = {{WIDTH{1'b0}}, w_abs_a}
                   * {{WIDTH{1'b0}}, w_abs_b};
  assign w_fprod_c = (w_neg_a ^ w_neg_b)
                   ? -w_fprod : w_fprod;
`endif

  // Control FSM, datapath and HI/LO; result writes are
  // placed after MTHI/MTLO so a same-edge result wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (i_we_hi) r_hi <= i_wdata;
      if (i_we_lo) r_lo <= i_wdata;
      if (i_cancel) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_op  <= i_op;
              r_a   <= w_abs_a;
              r_b   <= w_abs_b;
              r_sa  <= w_neg_a;
              r_sb  <= w_neg_b;
`ifdef MULDIV_FAST_MUL_EN
              if (!i_op[1]) begin
                r_hi    <= w_fprod_c[2*WIDTH-1:WIDTH];
                r_lo    <= w_fprod_c[WIDTH-1:0];
                r_state <= S_DONE;
              end else begin
                r_state <= S_PREP;
              end
`else
              r_state <= S_PREP;
`endif
            end
          end
          S_PREP: begin
            r_acc   <= '0;
            r_q     <= r_a;
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= S_ITER;
          end
          S_ITER: begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_FIX: begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_state <= S_DONE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_stall = i_start & (r_state != S_DONE)
                 & ~i_cancel;
  assign o_busy  = (r_state != S_IDLE)
                 && (r_state != S_DONE);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a
// plain-arithmetic reference model and directed corners.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         we_hi;
  logic         we_lo;
  logic [W-1:0] wdata;
  logic         stall;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit #(
    .WIDTH (W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_cancel (cancel),
    .i_we_hi  (we_hi),
    .i_we_lo  (we_lo),
    .i_wdata  (wdata),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    logic [2*W-1:0] p;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    e.name = "";
    case (o)
      2'd0: begin
        p = 64'(sx * sy);
        e.hi = p[2*W-1:W];
        e.lo = p[W-1:0];
      end
      2'd1: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[2*W-1:W];
        e.lo = p[W-1:0];
      end
      2'd2: begin
        if (y == 0) begin
          e.lo = '1;
          e.hi = x;
        end else if (x == 32'h8000_0000 && y == '1) begin
          e.lo = x;
          e.hi = '0;
        end else begin
          e.lo = W'(sx / sy);
          e.hi = W'(sx % sy);
        end
      end
      default: begin
        if (y == 0) begin
          e.lo = '1;
          e.hi = x;
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Completion is the cycle the instruction leaves E.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && start && !cancel && !stall) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: hi=%h lo=%h",
                   hi, lo);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input string nm);
    exp_t e;
    int   cyc;
    int   exp_cyc;
    bit   done;
    e = model(o, x, y);
    e.name = nm;
    cyc = 0;
    done = 1'b0;
    exp_cyc = W + 3;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) exp_cyc = 1;
`endif
    sb_q.push_back(e);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (stall) cyc++;
      else done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, expected %0d",
               nm, cyc, exp_cyc);
    end
    chk({nm, "_stall_cycles"}, W'(cyc), W'(exp_cyc));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    #1;
    chk({nm, "_idle_after_done"}, W'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ph;
    logic [W-1:0] pl;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    wdata = '0;
    #2;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_stall_low", W'(stall), 0);
    start = 1'b1;
    #1;
    chk("rst_stall_follows_start", W'(stall), 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'd3, 32'hFFFF_FFFF, 32'd0, "divu_by0");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'd2, 32'hFFFF_0000, 32'd0, "div_neg_by0");
    run_op(2'd2, 32'h0000_0064, 32'hFFFF_FFF9, "div_pos_neg");
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, "multu_ff_2");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_min");

    we_lo = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    we_lo = 1'b0;
    chk("mtlo_idle", lo, 32'h1234);

    we_hi = 1'b1;
    wdata = 32'h5555_5555;
    run_op(2'd3, 32'd1000, 32'd7, "fix_beats_mthi");
    we_hi = 1'b0;
    chk("mthi_after_done", hi, 32'h5555_5555);

    ph = hi;
    pl = lo;
    op = 2'd2;
    a = 32'd12345;
    b = 32'd11;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("cancel_busy_before", W'(busy), 1);
    cancel = 1'b1;
    #1;
    chk("cancel_stall_low", W'(stall), 0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_idle", W'(busy), 0);
    chk("cancel_hi_kept", hi, ph);
    chk("cancel_lo_kept", lo, pl);
    run_op(2'd2, 32'hFFFF_FF00, 32'd3, "after_cancel");

    we_hi = 1'b1;
    wdata = 32'hAA;
    @(posedge clk);
    #1;
    we_hi = 1'b0;
    chk("mthi_idle", hi, 32'hAA);
    op = 2'd2;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", W'(busy), 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_result_hi", hi, 0);
    chk("midrst_no_result_lo", lo, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = W'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        4: rb = -W'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, ra, rb, $sformatf("rnd%0d", i));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", W'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
